// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read.
module sync_fifo #(
    parameter int unsigned Depth          = 4,
    parameter int unsigned Width          = 8,
    parameter int unsigned AlmostFullThr  = Depth - 1,
    parameter int unsigned AlmostEmptyThr = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [Width-1:0] i_wr_data,
    output logic             o_wr_full,
    output logic             o_wr_almost_full,
    output logic             o_overflow,
    input  logic             i_rd_en,
    output logic [Width-1:0] o_rd_data,
    output logic             o_rd_empty,
    output logic             o_rd_almost_empty,
    output logic             o_underflow,
    output logic [$clog2(Depth+1)-1:0] o_count
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             wr_acc;
    logic             rd_acc;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Status decodes of the registered occupancy
    assign o_wr_full         = (count == CW'(Depth));
    assign o_wr_almost_full  = (count >= CW'(AlmostFullThr));
    assign o_rd_empty        = (count == '0);
    assign o_rd_almost_empty = (count <= CW'(AlmostEmptyThr));
    assign o_count           = count;
    assign o_overflow        = overflow;
    assign o_underflow       = underflow;

    assign wr_acc = i_wr_en && !o_wr_full;
    assign rd_acc = i_rd_en && !o_rd_empty;

    // Pointers, occupancy and sticky error flags; flush outranks any request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_acc) rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (i_wr_en && o_wr_full)  overflow  <= 1'b1;
            if (i_rd_en && o_rd_empty) underflow <= 1'b1;
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc && !i_flush) mem[wr_idx] <= i_wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_rd_data = o_rd_empty ? '0 : mem[rd_idx];
`else
    logic [Width-1:0] rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (i_flush) begin
            rd_data <= '0;
        end else if (rd_acc) begin
            rd_data <= mem[rd_idx];
        end
    end

    assign o_rd_data = rd_data;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (Depth 4, Width 8, default thresholds).
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       i_flush;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       o_wr_full;
    logic       o_wr_almost_full;
    logic       o_overflow;
    logic       i_rd_en;
    logic [7:0] o_rd_data;
    logic       o_rd_empty;
    logic       o_rd_almost_empty;
    logic       o_underflow;
    logic [2:0] o_count;

    int n_cmp;
    int n_err;

    sync_fifo #(.Depth(4), .Width(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_flush           (i_flush),
        .i_wr_en           (i_wr_en),
        .i_wr_data         (i_wr_data),
        .o_wr_full         (o_wr_full),
        .o_wr_almost_full  (o_wr_almost_full),
        .o_overflow        (o_overflow),
        .i_rd_en           (i_rd_en),
        .o_rd_data         (o_rd_data),
        .o_rd_empty        (o_rd_empty),
        .o_rd_almost_empty (o_rd_almost_empty),
        .o_underflow       (o_underflow),
        .o_count           (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic fl);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        i_flush   = fl;
    endtask

    logic [7:0] fill [4];
    logic [7:0] wrap_exp [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_exp = '{8'hA1, 8'hA2, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();

        check("rst_count", 32'(o_count), 32'd0);
        check("rst_empty", 32'(o_rd_empty), 32'd1);
        check("rst_full", 32'(o_wr_full), 32'd0);
        check("rst_aempty", 32'(o_rd_almost_empty), 32'd1);
        check("rst_afull", 32'(o_wr_almost_full), 32'd0);
        check("rst_ovf", 32'(o_overflow), 32'd0);
        check("rst_unf", 32'(o_underflow), 32'd0);
        check("rst_data", 32'(o_rd_data), 32'd0);
        rst_n = 1'b1;

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill[i], 1'b0, 1'b0);
            tick();
            check("fill_count", 32'(o_count), 32'(i + 1));
            check("fill_afull", 32'(o_wr_almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
            check("fill_aempty", 32'(o_rd_almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
        end
        check("full", 32'(o_wr_full), 32'd1);

        // Write while full is dropped
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        check("ovf_set", 32'(o_overflow), 32'd1);
        check("ovf_count", 32'(o_count), 32'd4);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
            check("drain_head", 32'(o_rd_data), 32'(fill[i]));
`endif
            tick();
`ifndef SYNC_FIFO_FWFT_EN
            check("drain_data", 32'(o_rd_data), 32'(fill[i]));
`endif
        end
        check("drain_empty", 32'(o_rd_empty), 32'd1);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Read while empty
        tick();
        check("unf_set", 32'(o_underflow), 32'd1);
        check("unf_count", 32'(o_count), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        check("unf_data", 32'(o_rd_data), 32'd0);
`else
        check("unf_data_hold", 32'(o_rd_data), 32'h44);
`endif

        // Flush clears errors
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        check("fl_ovf", 32'(o_overflow), 32'd0);
        check("fl_unf", 32'(o_underflow), 32'd0);
        check("fl_data", 32'(o_rd_data), 32'd0);

        // Count 2, then simultaneous read+write across pointer wrap
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hA2, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'hA5, 1'b1, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
            check("wrap_head", 32'(o_rd_data), 32'(wrap_exp[i]));
`endif
            tick();
`ifndef SYNC_FIFO_FWFT_EN
            check("wrap_data", 32'(o_rd_data), 32'(wrap_exp[i]));
`endif
            check("wrap_count", 32'(o_count), 32'd2);
        end
        check("wrap_ovf", 32'(o_overflow), 32'd0);
        check("wrap_unf", 32'(o_underflow), 32'd0);

        // Reach count 3 with overflow set, then flush with a concurrent write
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        tick();
        check("c3_ovf", 32'(o_overflow), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("c3_count", 32'(o_count), 32'd3);
`ifndef SYNC_FIFO_FWFT_EN
        check("c3_data", 32'(o_rd_data), 32'hA5);
`endif
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        tick();
        check("flw_count", 32'(o_count), 32'd0);
        check("flw_empty", 32'(o_rd_empty), 32'd1);
        check("flw_ovf", 32'(o_overflow), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("flw_discard", 32'(o_count), 32'd0);

        // Simultaneous write+read while empty: write wins, underflow set
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        tick();
        check("we_count", 32'(o_count), 32'd1);
        check("we_unf", 32'(o_underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
        check("we_data", 32'(o_rd_data), 32'h3C);
`else
        check("we_data", 32'(o_rd_data), 32'h00);
`endif
        drive(1'b1, 8'h4D, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h5E, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h6F, 1'b0, 1'b0);
        tick();
        check("wf_full", 32'(o_wr_full), 32'd1);

        // Simultaneous write+read while full: read wins, overflow set
        drive(1'b1, 8'h70, 1'b1, 1'b0);
        tick();
        check("wf_count", 32'(o_count), 32'd3);
        check("wf_ovf", 32'(o_overflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
        check("wf_data", 32'(o_rd_data), 32'h4D);
`else
        check("wf_data", 32'(o_rd_data), 32'h3C);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_empty", 32'(o_rd_empty), 32'd1);
        check("arst_ovf", 32'(o_overflow), 32'd0);
        check("arst_unf", 32'(o_underflow), 32'd0);
        check("arst_data", 32'(o_rd_data), 32'd0);
        #1;
        rst_n = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft_data", 32'(o_rd_data), 32'h7E);
        check("fwft_nempty", 32'(o_rd_empty), 32'd0);
        tick();
        check("fwft_hold", 32'(o_rd_data), 32'h7E);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("fwft_empty", 32'(o_rd_empty), 32'd1);
        check("fwft_zero", 32'(o_rd_data), 32'd0);
`else
        drive(1'b1, 8'h7E, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        check("std_nolat", 32'(o_rd_data), 32'd0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check("std_data", 32'(o_rd_data), 32'h7E);
        check("std_empty", 32'(o_rd_empty), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
